// File: rtl/wishbone_interconnect_param.sv
// Single-master Wishbone interconnect: decodes m_adr_i[31:24] to a slave and registers the access.
// Unmapped or non-responding slaves complete with an error ack; slave interrupts are OR-ed into m_int_o.
module wishbone_interconnect_param #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_we_i,
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    input  logic [3:0]                 m_sel_i,
    input  logic [31:0]                m_adr_i,
    input  logic [31:0]                m_dat_i,
    output logic [31:0]                m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic                       m_int_o,
    output logic [NUM_SLAVES-1:0]      s_we_o,
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    output logic [3:0]                 s_sel_o,
    output logic [31:0]                s_adr_o,
    output logic [31:0]                s_dat_o,
    input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i,
    input  logic [NUM_SLAVES-1:0]      s_int_i
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            idx_q;
    logic                  we_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_SLAVES-1:0] stb_q, stb_d, req_onehot;
    logic                  ack_d, err_d;
    logic [31:0]           dat_d, sel_dat;
    logic                  sel_ack;
    logic                  req, mapped, timeout_hit;
    logic [CNT_W:0]        cnt_inc;

    assign req         = m_cyc_i & m_stb_i;
    assign mapped      = 32'(m_adr_i[31:24]) < NUM_SLAVES;
    assign cnt_inc     = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
    // Expires during the TIMEOUT_CYCLES-th ACTIVE cycle so the error ack lands one cycle later
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= (CNT_W+1)'(TIMEOUT_CYCLES));

    assign s_cyc_o = stb_q;
    assign s_stb_o = stb_q;
    assign s_we_o  = stb_q & {NUM_SLAVES{we_q}};

    // Selected-slave response mux and request one-hot decode
    always_comb begin
        sel_ack    = 1'b0;
        sel_dat    = '0;
        req_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == 8'(i)) begin
                sel_ack = s_ack_i[i];
                sel_dat = s_dat_i[32*i +: 32];
            end
            req_onehot[i] = (m_adr_i[31:24] == 8'(i));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a master abort takes priority over a coincident slave ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = mapped ? ACTIVE : RESP;
            ACTIVE: begin
                if (!m_cyc_i)                   state_d = IDLE;
                else if (sel_ack || timeout_hit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered master response and slave strobes
    always_comb begin
        ack_d = 1'b0;
        err_d = 1'b0;
        dat_d = m_dat_o;
        stb_d = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mapped) begin
                        stb_d = req_onehot;
                    end else begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                        dat_d = ERR_DATA;
                    end
                end
            end
            ACTIVE: begin
                if (m_cyc_i) begin
                    if (sel_ack) begin
                        ack_d = 1'b1;
                        dat_d = sel_dat;
                    end else if (timeout_hit) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                        dat_d = ERR_DATA;
                    end else begin
                        stb_d = stb_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= '0;
            m_int_o <= 1'b0;
            stb_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            s_sel_o <= '0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            cnt_q   <= '0;
        end else begin
            m_ack_o <= ack_d;
            m_err_o <= err_d;
            m_dat_o <= dat_d;
            m_int_o <= |s_int_i;
            stb_q   <= stb_d;
            if (state_q == IDLE && req) begin
                idx_q   <= m_adr_i[31:24];
                we_q    <= m_we_i;
                s_sel_o <= m_sel_i;
                s_adr_o <= {8'h00, m_adr_i[23:0]};
                s_dat_o <= m_dat_i;
            end
            if (state_q == IDLE)
                cnt_q <= '0;
            else if (state_q == ACTIVE && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wishbone_interconnect_param.sv
// Bench for wishbone_interconnect_param: directed scenarios plus randomized transactions
// checked against a per-transaction outcome model (mapped?, ack delay vs. timeout).
module tb_wishbone_interconnect_param;

    localparam int unsigned NS = 4;
    localparam int unsigned TO = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic            m_we_i, m_cyc_i, m_stb_i;
    logic [3:0]      m_sel_i;
    logic [31:0]     m_adr_i, m_dat_i, m_dat_o;
    logic            m_ack_o, m_err_o, m_int_o;
    logic [NS-1:0]   s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]      s_sel_o;
    logic [31:0]     s_adr_o, s_dat_o;
    logic [32*NS-1:0] s_dat_i;
    logic [NS-1:0]   s_ack_i, s_int_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] sdata [NS];

    wishbone_interconnect_param #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_int_o(m_int_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One master access. d = strobe cycle in which the slave acks (0 = never).
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int d, input logic stray);
        int idx;
        logic mapped, ok;
        int done;
        logic [31:0] exp_dat;
        logic [NS-1:0] onehot;
        idx    = int'(adr[31:24]);
        mapped = (idx < int'(NS));
        for (int i = 0; i < int'(NS); i++) begin
            sdata[i] = $urandom;
            s_dat_i[32*i +: 32] = sdata[i];
        end
        ok      = mapped && d != 0 && d <= int'(TO);
        done    = !mapped ? 1 : (ok ? d + 1 : int'(TO) + 1);
        exp_dat = ok ? sdata[idx] : ERR;
        onehot  = mapped ? NS'(1 << idx) : '0;
        @(negedge clk);
        m_we_i = we; m_adr_i = adr; m_dat_i = dat; m_sel_i = sel;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; s_ack_i = '0;
        for (int n = 1; n <= done; n++) begin
            @(negedge clk);
            check($sformatf("stb@%0d", n), 32'(s_stb_o), (n < done) ? 32'(onehot) : 32'd0);
            check($sformatf("cyc@%0d", n), 32'(s_cyc_o), (n < done) ? 32'(onehot) : 32'd0);
            check($sformatf("we@%0d", n), 32'(s_we_o), (n < done && we) ? 32'(onehot) : 32'd0);
            check($sformatf("ack@%0d", n), 32'(m_ack_o), 32'(n == done));
            check($sformatf("err@%0d", n), 32'(m_err_o), 32'(n == done && !ok));
            if (n == done) check("m_dat", m_dat_o, exp_dat);
            if (n == 1) begin
                check("s_adr", s_adr_o, {8'h00, adr[23:0]});
                check("s_dat", s_dat_o, dat);
                check("s_sel", 32'(s_sel_o), 32'(sel));
            end
            s_ack_i = stray ? (NS'($urandom) & ~onehot) : '0;
            if (mapped && n == d) s_ack_i = s_ack_i | onehot;
            if (n == done) begin m_cyc_i = 1'b0; m_stb_i = 1'b0; end
        end
    endtask

    initial begin
        rst = 1'b1; m_we_i = 0; m_cyc_i = 0; m_stb_i = 0; m_sel_i = '0;
        m_adr_i = '0; m_dat_i = '0; s_dat_i = '0; s_ack_i = '0; s_int_i = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ack", 32'(m_ack_o), 0);
        check("rst_err", 32'(m_err_o), 0);
        check("rst_dat", m_dat_o, 0);
        check("rst_stb", 32'(s_stb_o), 0);
        check("rst_adr", s_adr_o, 0);
        check("rst_int", 32'(m_int_o), 0);
        rst = 1'b0;

        // Directed: read slave 2, write slave 0, unmapped, timeout
        txn(1'b0, 32'h02000010, 32'h0, 4'hF, 1, 1'b0);
        sdata[2] = 32'h12345678; s_dat_i[64 +: 32] = 32'h12345678;
        txn(1'b1, 32'h00000004, 32'hA5A5A5A5, 4'b0011, 3, 1'b0);
        txn(1'b0, 32'h07000000, 32'h0, 4'hF, 1, 1'b0);
        txn(1'b0, 32'h01000020, 32'h0, 4'hF, 0, 1'b0);
        // Late ack from slave 1 after the timeout completion
        s_ack_i = 4'b0010;
        @(negedge clk); check("late_ack1", 32'(m_ack_o), 0);
        @(negedge clk); check("late_ack2", 32'(m_ack_o), 0);
        s_ack_i = '0;
        @(negedge clk); check("late_ack3", 32'(m_ack_o), 0);
        check("late_stb", 32'(s_stb_o), 0);

        // Explicit data value through slave 2
        for (int i = 0; i < int'(NS); i++) sdata[i] = 32'h0;
        @(negedge clk);
        m_we_i = 0; m_adr_i = 32'h02000010; m_cyc_i = 1; m_stb_i = 1;
        s_dat_i = '0; s_dat_i[64 +: 32] = 32'h12345678; s_ack_i = '0;
        @(negedge clk); check("rd2_stb", 32'(s_stb_o), 32'h4);
        s_ack_i = 4'b0100;
        @(negedge clk); check("rd2_ack", 32'(m_ack_o), 1);
        check("rd2_dat", m_dat_o, 32'h12345678);
        check("rd2_err", 32'(m_err_o), 0);
        m_cyc_i = 0; m_stb_i = 0; s_ack_i = '0;
        @(negedge clk); check("rd2_pulse", 32'(m_ack_o), 0);

        // Stray ack on slave 3 while slave 1 active
        @(negedge clk);
        m_adr_i = 32'h01000000; m_cyc_i = 1; m_stb_i = 1;
        @(negedge clk); check("stray_stb", 32'(s_stb_o), 32'h2);
        s_ack_i = 4'b1000;
        @(negedge clk); check("stray_ack", 32'(m_ack_o), 0);
        check("stray_stb2", 32'(s_stb_o), 32'h2);
        // Abort: drop m_cyc_i while active
        s_ack_i = '0; m_cyc_i = 0; m_stb_i = 0;
        @(negedge clk); check("abort_stb", 32'(s_stb_o), 0);
        check("abort_ack", 32'(m_ack_o), 0);
        @(negedge clk); check("abort_ack2", 32'(m_ack_o), 0);

        // Reset mid-access, then a normal access
        m_adr_i = 32'h02000008; m_cyc_i = 1; m_stb_i = 1;
        @(negedge clk); check("pre_rst_stb", 32'(s_stb_o), 32'h4);
        rst = 1'b1; m_cyc_i = 0; m_stb_i = 0;
        @(negedge clk);
        check("mid_rst_stb", 32'(s_stb_o), 0);
        check("mid_rst_ack", 32'(m_ack_o), 0);
        check("mid_rst_dat", m_dat_o, 0);
        check("mid_rst_adr", s_adr_o, 0);
        rst = 1'b0;
        @(negedge clk); check("post_rst_ack", 32'(m_ack_o), 0);
        txn(1'b0, 32'h03000044, 32'h0, 4'hF, 2, 1'b0);

        // Interrupt aggregation with one cycle latency
        s_int_i = 4'b0100;
        check("int_before", 32'(m_int_o), 0);
        @(negedge clk); check("int_set", 32'(m_int_o), 1);
        s_int_i = '0;
        @(negedge clk); check("int_clr", 32'(m_int_o), 0);

        // Randomized accesses, including unmapped slaves, timeouts and stray acks
        for (int k = 0; k < 40; k++) begin
            txn(1'($urandom), {8'($urandom_range(0, 5)), 24'($urandom)}, $urandom,
                4'($urandom), int'($urandom_range(0, 10)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
